// File: rtl/load_scoreboard.sv
// Producer-side hazard controller: tracks in-flight long-latency destinations, stalls decode
// on RAW/WAW hazards against them, and drives the post-branch flush. Optional: SCOREBOARD_BYPASS_EN.
module load_scoreboard #(
    parameter int unsigned MAX_PENDING  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       decode_valid_i,
    input  logic [4:0] rs1_decode_i,
    input  logic [4:0] rs2_decode_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic [4:0] rd_decode_i,
    input  logic       longlat_decode_i,
    input  logic       wb_valid_i,
    input  logic [4:0] wb_rd_i,
    input  logic       branch_taken_i,
    output logic       stall_decode_o,
    output logic       flush_o,
    output logic [4:0] pending_cnt_o,
    output logic       pending_full_o
);

    localparam int unsigned FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);
    localparam logic [FCW-1:0] FLUSH_ONE  = FCW'(1);
    localparam logic [4:0]     MAX_CNT    = 5'(MAX_PENDING);

    typedef enum logic {
        IDLE,
        FLUSHING
    } flush_state_e;

    flush_state_e   state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]    pending_q, pending_d;
    logic [4:0]     cnt_q, cnt_d;

    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] p_eff;
    logic        flush;
    logic        full;
    logic        hazard;
    logic        stall;
    logic        issue;
    logic        cnt_inc;
    logic        cnt_dec;

    always_comb begin
        clr_vec = 32'd0;
        if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            clr_vec[wb_rd_i] = 1'b1;
        end
    end

`ifdef SCOREBOARD_BYPASS_EN
    // A same-cycle writeback is visible to decode through a write-first register file.
    assign p_eff = pending_q & ~clr_vec;
`else
    assign p_eff = pending_q;
`endif

    assign flush = (state_q == FLUSHING);
    assign full  = (cnt_q == MAX_CNT);

    always_comb begin
        hazard = 1'b0;
        if (rs1_used_i && (rs1_decode_i != 5'd0) && p_eff[rs1_decode_i]) begin
            hazard = 1'b1;
        end
        if (rs2_used_i && (rs2_decode_i != 5'd0) && p_eff[rs2_decode_i]) begin
            hazard = 1'b1;
        end
        if (longlat_decode_i && (rd_decode_i != 5'd0) && p_eff[rd_decode_i]) begin
            hazard = 1'b1;
        end
        if (longlat_decode_i && full) begin
            hazard = 1'b1;
        end
    end

    assign stall = decode_valid_i && !flush && hazard;
    assign issue = decode_valid_i && !stall && !flush && !branch_taken_i;

    always_comb begin
        set_vec = 32'd0;
        if (issue && longlat_decode_i && (rd_decode_i != 5'd0)) begin
            set_vec[rd_decode_i] = 1'b1;
        end
    end

    // Set beats clear on the same register, so a WAW reissue keeps the bit and the count.
    assign pending_d = (pending_q & ~clr_vec) | set_vec;
    assign cnt_inc   = |(set_vec & ~pending_q);
    assign cnt_dec   = |(clr_vec & pending_q & ~set_vec);
    assign cnt_d     = cnt_q + {4'd0, cnt_inc} - {4'd0, cnt_dec};

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (branch_taken_i) begin
                    state_d     = FLUSHING;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            FLUSHING: begin
                if (branch_taken_i) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q <= FLUSH_ONE) begin
                    flush_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_ONE;
                end
            end
            default: begin
                state_d     = IDLE;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            pending_q   <= 32'd0;
            cnt_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall_decode_o = stall;
    assign flush_o        = flush;
    assign pending_cnt_o  = cnt_q;
    assign pending_full_o = full;

endmodule

// File: tb/tb_load_scoreboard.sv
// Scoreboard bench for load_scoreboard: per-cycle expected {stall, flush, full, cnt} values are
// queued as stimulus is driven and compared when the outputs are sampled.
module tb_load_scoreboard;

    logic       clk_i;
    logic       rst_i;
    logic       decode_valid_i;
    logic [4:0] rs1_decode_i;
    logic [4:0] rs2_decode_i;
    logic       rs1_used_i;
    logic       rs2_used_i;
    logic [4:0] rd_decode_i;
    logic       longlat_decode_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic       branch_taken_i;
    logic       stall_decode_o;
    logic       flush_o;
    logic [4:0] pending_cnt_o;
    logic       pending_full_o;

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       ll;
        logic       wbv;
        logic [4:0] wbrd;
        logic       br;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [7:0] e;
    } row_t;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    load_scoreboard #(.MAX_PENDING(4), .FLUSH_CYCLES(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .decode_valid_i   (decode_valid_i),
        .rs1_decode_i     (rs1_decode_i),
        .rs2_decode_i     (rs2_decode_i),
        .rs1_used_i       (rs1_used_i),
        .rs2_used_i       (rs2_used_i),
        .rd_decode_i      (rd_decode_i),
        .longlat_decode_i (longlat_decode_i),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_i          (wb_rd_i),
        .branch_taken_i   (branch_taken_i),
        .stall_decode_o   (stall_decode_o),
        .flush_o          (flush_o),
        .pending_cnt_o    (pending_cnt_o),
        .pending_full_o   (pending_full_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t load_s(input logic [4:0] r);
        stim_t s;
        s    = '0;
        s.dv = 1'b1;
        s.rd = r;
        s.ll = 1'b1;
        return s;
    endfunction

    function automatic stim_t read_s(input logic [4:0] r);
        stim_t s;
        s    = '0;
        s.dv = 1'b1;
        s.rs1 = r;
        s.u1 = 1'b1;
        s.rd = 5'd10;
        return s;
    endfunction

    function automatic stim_t with_wb(input stim_t si, input logic [4:0] r);
        stim_t s;
        s      = si;
        s.wbv  = 1'b1;
        s.wbrd = r;
        return s;
    endfunction

    function automatic stim_t with_br(input stim_t si);
        stim_t s;
        s    = si;
        s.br = 1'b1;
        return s;
    endfunction

    function automatic stim_t with_rst(input stim_t si);
        stim_t s;
        s     = si;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic logic [7:0] exp_v(input int st, input int fl, input int fu, input int c);
        return {st[0], fl[0], fu[0], c[4:0]};
    endfunction

    function automatic row_t mk(input stim_t s, input logic [7:0] e);
        row_t r;
        r.s = s;
        r.e = e;
        return r;
    endfunction

    task automatic apply(input stim_t s);
        rst_i            = s.rst;
        decode_valid_i   = s.dv;
        rs1_decode_i     = s.rs1;
        rs1_used_i       = s.u1;
        rs2_decode_i     = s.rs2;
        rs2_used_i       = s.u2;
        rd_decode_i      = s.rd;
        longlat_decode_i = s.ll;
        wb_valid_i       = s.wbv;
        wb_rd_i          = s.wbrd;
        branch_taken_i   = s.br;
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        apply(with_rst(idle_s()));
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [7:0] e;
        reset_dut();
        rows.push_back(mk(idle_s(),      exp_v(0, 0, 0, 0)));
        rows.push_back(mk(read_s(5'd5),  exp_v(0, 0, 0, 0)));
        rows.push_back(mk(load_s(5'd31), exp_v(0, 0, 0, 0)));
        rows.push_back(mk(read_s(5'd31), exp_v(1, 0, 0, 1)));
        foreach (rows[i]) begin
            @(negedge clk_i);
            apply(rows[i].s);
            sb.push_back(rows[i].e);
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall_decode_o, flush_o, pending_full_o, pending_cnt_o} !== e) begin
                errors++;
                $display("[TB] FAIL reset[%0d] {stall,flush,full,cnt} got=%b exp=%b", i,
                         {stall_decode_o, flush_o, pending_full_o, pending_cnt_o}, e);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [7:0] e;
        reset_dut();
        rows.push_back(mk(load_s(5'd5),                 exp_v(0, 0, 0, 0)));
        rows.push_back(mk(read_s(5'd5),                 exp_v(1, 0, 0, 1)));
        rows.push_back(mk(read_s(5'd5),                 exp_v(1, 0, 0, 1)));
`ifdef SCOREBOARD_BYPASS_EN
        rows.push_back(mk(with_wb(read_s(5'd5), 5'd5),  exp_v(0, 0, 0, 1)));
        rows.push_back(mk(idle_s(),                     exp_v(0, 0, 0, 0)));
`else
        rows.push_back(mk(with_wb(read_s(5'd5), 5'd5),  exp_v(1, 0, 0, 1)));
        rows.push_back(mk(read_s(5'd5),                 exp_v(0, 0, 0, 0)));
`endif
        rows.push_back(mk(idle_s(),                     exp_v(0, 0, 0, 0)));
        foreach (rows[i]) begin
            @(negedge clk_i);
            apply(rows[i].s);
            sb.push_back(rows[i].e);
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall_decode_o, flush_o, pending_full_o, pending_cnt_o} !== e) begin
                errors++;
                $display("[TB] FAIL load_use[%0d] {stall,flush,full,cnt} got=%b exp=%b", i,
                         {stall_decode_o, flush_o, pending_full_o, pending_cnt_o}, e);
            end
        end
    endtask

    task automatic test_x0();
        row_t rows[$];
        logic [7:0] e;
        stim_t s;
        reset_dut();
        s = load_s(5'd0);
        s.rs1 = 5'd0;
        s.u1  = 1'b1;
        s.rs2 = 5'd0;
        s.u2  = 1'b1;
        rows.push_back(mk(load_s(5'd0), exp_v(0, 0, 0, 0)));
        rows.push_back(mk(read_s(5'd0), exp_v(0, 0, 0, 0)));
        rows.push_back(mk(s,            exp_v(0, 0, 0, 0)));
        rows.push_back(mk(with_wb(idle_s(), 5'd0), exp_v(0, 0, 0, 0)));
        rows.push_back(mk(idle_s(),     exp_v(0, 0, 0, 0)));
        foreach (rows[i]) begin
            @(negedge clk_i);
            apply(rows[i].s);
            sb.push_back(rows[i].e);
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall_decode_o, flush_o, pending_full_o, pending_cnt_o} !== e) begin
                errors++;
                $display("[TB] FAIL x0[%0d] {stall,flush,full,cnt} got=%b exp=%b", i,
                         {stall_decode_o, flush_o, pending_full_o, pending_cnt_o}, e);
            end
        end
    endtask

    task automatic test_full();
        row_t rows[$];
        logic [7:0] e;
        stim_t add;
        reset_dut();
        add = '0;
        add.dv  = 1'b1;
        add.rs1 = 5'd8;
        add.u1  = 1'b1;
        add.rs2 = 5'd9;
        add.u2  = 1'b1;
        add.rd  = 5'd10;
        rows.push_back(mk(load_s(5'd1),                exp_v(0, 0, 0, 0)));
        rows.push_back(mk(load_s(5'd2),                exp_v(0, 0, 0, 1)));
        rows.push_back(mk(load_s(5'd3),                exp_v(0, 0, 0, 2)));
        rows.push_back(mk(load_s(5'd4),                exp_v(0, 0, 0, 3)));
        rows.push_back(mk(load_s(5'd6),                exp_v(1, 0, 1, 4)));
        rows.push_back(mk(add,                         exp_v(0, 0, 1, 4)));
        rows.push_back(mk(with_wb(load_s(5'd6), 5'd2), exp_v(1, 0, 1, 4)));
        rows.push_back(mk(load_s(5'd6),                exp_v(0, 0, 0, 3)));
        rows.push_back(mk(read_s(5'd6),                exp_v(1, 0, 1, 4)));
        rows.push_back(mk(read_s(5'd2),                exp_v(0, 0, 1, 4)));
        foreach (rows[i]) begin
            @(negedge clk_i);
            apply(rows[i].s);
            sb.push_back(rows[i].e);
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall_decode_o, flush_o, pending_full_o, pending_cnt_o} !== e) begin
                errors++;
                $display("[TB] FAIL full[%0d] {stall,flush,full,cnt} got=%b exp=%b", i,
                         {stall_decode_o, flush_o, pending_full_o, pending_cnt_o}, e);
            end
        end
    endtask

    task automatic test_waw();
        row_t rows[$];
        logic [7:0] e;
        reset_dut();
        rows.push_back(mk(load_s(5'd7),                exp_v(0, 0, 0, 0)));
        rows.push_back(mk(idle_s(),                    exp_v(0, 0, 0, 1)));
`ifdef SCOREBOARD_BYPASS_EN
        rows.push_back(mk(with_wb(load_s(5'd7), 5'd7), exp_v(0, 0, 0, 1)));
        rows.push_back(mk(read_s(5'd7),                exp_v(1, 0, 0, 1)));
`else
        rows.push_back(mk(with_wb(load_s(5'd7), 5'd7), exp_v(1, 0, 0, 1)));
        rows.push_back(mk(load_s(5'd7),                exp_v(0, 0, 0, 0)));
`endif
        rows.push_back(mk(read_s(5'd7),                exp_v(1, 0, 0, 1)));
        rows.push_back(mk(with_wb(idle_s(), 5'd12),    exp_v(0, 0, 0, 1)));
        rows.push_back(mk(idle_s(),                    exp_v(0, 0, 0, 1)));
        foreach (rows[i]) begin
            @(negedge clk_i);
            apply(rows[i].s);
            sb.push_back(rows[i].e);
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall_decode_o, flush_o, pending_full_o, pending_cnt_o} !== e) begin
                errors++;
                $display("[TB] FAIL waw[%0d] {stall,flush,full,cnt} got=%b exp=%b", i,
                         {stall_decode_o, flush_o, pending_full_o, pending_cnt_o}, e);
            end
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        logic [7:0] e;
        reset_dut();
        rows.push_back(mk(load_s(5'd5),           exp_v(0, 0, 0, 0)));
        rows.push_back(mk(read_s(5'd5),           exp_v(1, 0, 0, 1)));
        rows.push_back(mk(with_br(read_s(5'd5)),  exp_v(1, 0, 0, 1)));
        rows.push_back(mk(with_br(read_s(5'd5)),  exp_v(0, 1, 0, 1)));
        rows.push_back(mk(read_s(5'd5),           exp_v(0, 1, 0, 1)));
        rows.push_back(mk(read_s(5'd5),           exp_v(0, 1, 0, 1)));
        rows.push_back(mk(read_s(5'd5),           exp_v(1, 0, 0, 1)));
        rows.push_back(mk(with_br(read_s(5'd5)),  exp_v(1, 0, 0, 1)));
        rows.push_back(mk(load_s(5'd9),           exp_v(0, 1, 0, 1)));
        rows.push_back(mk(idle_s(),               exp_v(0, 1, 0, 1)));
        rows.push_back(mk(read_s(5'd9),           exp_v(0, 0, 0, 1)));
        rows.push_back(mk(with_br(load_s(5'd9)),  exp_v(0, 0, 0, 1)));
        rows.push_back(mk(idle_s(),               exp_v(0, 1, 0, 1)));
        rows.push_back(mk(idle_s(),               exp_v(0, 1, 0, 1)));
        rows.push_back(mk(read_s(5'd9),           exp_v(0, 0, 0, 1)));
        foreach (rows[i]) begin
            @(negedge clk_i);
            apply(rows[i].s);
            sb.push_back(rows[i].e);
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall_decode_o, flush_o, pending_full_o, pending_cnt_o} !== e) begin
                errors++;
                $display("[TB] FAIL flush[%0d] {stall,flush,full,cnt} got=%b exp=%b", i,
                         {stall_decode_o, flush_o, pending_full_o, pending_cnt_o}, e);
            end
        end
    endtask

    task automatic test_reset_midflight();
        row_t rows[$];
        logic [7:0] e;
        reset_dut();
        rows.push_back(mk(load_s(5'd1),                   exp_v(0, 0, 0, 0)));
        rows.push_back(mk(load_s(5'd2),                   exp_v(0, 0, 0, 1)));
        rows.push_back(mk(load_s(5'd3),                   exp_v(0, 0, 0, 2)));
        rows.push_back(mk(with_br(idle_s()),              exp_v(0, 0, 0, 3)));
        rows.push_back(mk(read_s(5'd1),                   exp_v(0, 1, 0, 3)));
        rows.push_back(mk(with_rst(read_s(5'd1)),         exp_v(0, 1, 0, 3)));
        rows.push_back(mk(read_s(5'd1),                   exp_v(0, 0, 0, 0)));
        rows.push_back(mk(read_s(5'd2),                   exp_v(0, 0, 0, 0)));
        rows.push_back(mk(idle_s(),                       exp_v(0, 0, 0, 0)));
        foreach (rows[i]) begin
            @(negedge clk_i);
            apply(rows[i].s);
            sb.push_back(rows[i].e);
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall_decode_o, flush_o, pending_full_o, pending_cnt_o} !== e) begin
                errors++;
                $display("[TB] FAIL reset_midflight[%0d] {stall,flush,full,cnt} got=%b exp=%b", i,
                         {stall_decode_o, flush_o, pending_full_o, pending_cnt_o}, e);
            end
        end
    endtask

    initial begin
        apply(idle_s());
        test_reset();
        test_load_use();
        test_x0();
        test_full();
        test_waw();
        test_flush();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Producer-side hazard controller for the 5-stage pipeline. It tracks destination registers of in-flight long-latency results (loads, multi-cycle ops) that the EXE/MEM forwarding paths cannot supply. It stalls decode on RAW/WAW hazards against those registers and generates the multi-cycle flush after a taken branch. It sits beside the forwarding unit: forwarding covers single-cycle results, this block covers everything that only becomes valid at writeback.

## Interface
Parameters:
- `MAX_PENDING`, 4 — maximum simultaneously outstanding long-latency destinations (1..31).
- `FLUSH_CYCLES`, 2 — cycles `flush` stays high after a taken branch (≥1).

Ports:
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `decode_valid` in 1 — valid instruction in decode.
- `rs1_decode` in 5 — decode source 1 address.
- `rs2_decode` in 5 — decode source 2 address.
- `rs1_used` in 1 — instruction reads rs1.
- `rs2_used` in 1 — instruction reads rs2.
- `rd_decode` in 5 — decode destination.
- `longlat_decode` in 1 — decode instruction writes a non-forwardable result.
- `wb_valid` in 1 — long-latency result written back this cycle.
- `wb_rd` in 5 — writeback destination.
- `branch_taken` in 1 — taken branch resolved in EXE.
- `stall_decode` out 1 — hold PC/IF-ID, inject bubble into EXE.
- `flush` out 1 — kill IF/ID contents.
- `pending_cnt` out 5 — outstanding long-latency destinations.
- `pending_full` out 1 — `pending_cnt == MAX_PENDING`.

## Operation
- State: 32-bit `pending` bitmap (bit 0 never set), `pending_cnt`, flush down-counter.
- Effective pending `P_eff = pending` (see Configuration for the same-cycle writeback mask).
- `stall_decode = decode_valid && !flush && ((rs1_used && rs1_decode!=0 && P_eff[rs1_decode]) || (rs2_used && rs2_decode!=0 && P_eff[rs2_decode]) || (longlat_decode && rd_decode!=0 && P_eff[rd_decode]) || (longlat_decode && pending_full))`. Combinational.
- Issue: `issue = decode_valid && !stall_decode && !flush && !branch_taken`.
- Set: `issue && longlat_decode && rd_decode!=0` sets `pending[rd_decode]` at the next edge.
- Clear: `wb_valid && wb_rd!=0` clears `pending[wb_rd]`. A clear of a non-pending bit is a no-op and does not change the count.
- Same register set and clear in one cycle: set wins; count unchanged.
- Count: next `pending_cnt` = current + (set of a clear bit) − (effective clear of a set bit). It never exceeds `MAX_PENDING` and never underflows.
- Flush FSM: IDLE → on `branch_taken`, load counter with `FLUSH_CYCLES`, go to FLUSHING. In FLUSHING, `flush=1` and the counter decrements each cycle; return to IDLE when it reaches 0. `branch_taken` while FLUSHING reloads the counter to `FLUSH_CYCLES`.
- Stall/flush priority: flush overrides stall, so `stall_decode=0` while `flush=1`.

## Timing
- Reset values: `pending=0`, `pending_cnt=0`, `pending_full=0`, `flush=0`, `stall_decode=0`, FSM IDLE.
- `rst` mid-operation drops all pending state and any flush in progress at that edge.
- `stall_decode` is combinational from inputs and registered state, with zero latency.
- `flush` rises the cycle after `branch_taken` and stays high for exactly `FLUSH_CYCLES` cycles.
- A load issued in cycle N is visible in `pending` from cycle N+1. A dependent instruction in decode at N+1 stalls until the writeback cycle (with bypass) or the cycle after it (without).

## Configuration
- Macro `SCOREBOARD_BYPASS_EN`:
  - Defined: `P_eff = pending & ~(wb_valid && wb_rd!=0 ? 1<<wb_rd : 0)`. A writeback releases dependents in the same cycle. The register file must write-first.
  - Undefined: `P_eff = pending`, adding one extra stall cycle per writeback-resolved hazard.

## Test plan
- Load-use: issue load to x5 (longlat) at cycle 0; add reading x5 in decode cycles 1-3; `wb_valid`/`wb_rd=5` at cycle 3.
  - Bypass defined: `stall_decode=1` in cycles 1-2, 0 at cycle 3.
  - Bypass undefined: `stall_decode=1` in cycles 1-3, 0 at cycle 4.
  - Both: `pending_cnt` goes 0→1→0.
- x0 immunity: longlat issue with `rd_decode=0`, then a reader of x0 → no pending bit set, `pending_cnt=0`, `stall_decode` never asserted.
- Full: `MAX_PENDING=4`, issue loads to x1..x4 → `pending_full=1`. A fifth load to x6 stalls; a non-long-latency add with unrelated sources issues (`stall_decode=0`). `wb_rd=2` releases the load.
- WAW with simultaneous writeback (bypass defined): x7 pending, decode load to x7 while `wb_rd=7` → issues, `pending[7]` stays 1, `pending_cnt` unchanged.
- Flush: `FLUSH_CYCLES=2`, `branch_taken` at cycle 10 with a dependent stalled instruction in decode → no issue at 10, `flush=1` at cycles 11-12, `stall_decode=0` at 11-12. A second `branch_taken` at 11 extends `flush` through cycle 13.
- Reset mid-flight: 3 pending loads plus active flush, `rst` for 1 cycle → next cycle `pending_cnt=0`, `flush=0`, `stall_decode=0`, and a prior-dependent reader issues.
